// File: rtl/ml_y_gen.sv
// ml_y_gen: computes y_hat = R*x for a 4x4 upper-triangular R and QPSK symbols,
// one R word per cycle through a single shared multiplier.
module ml_y_gen #(
    parameter int DATA_WIDTH = 20,
    parameter int QPSK_AMP   = 46341
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [7:0]                i_x_hardbit,
    input  logic [16*DATA_WIDTH-1:0]  i_r,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [8*DATA_WIDTH-1:0]   o_y_hat
);
    localparam int PW = DATA_WIDTH + 18;
    localparam logic [16:0] AMP = 17'(QPSK_AMP);
    localparam logic signed [22:0] SMAX = 23'((1 <<< (DATA_WIDTH - 1)) - 1);
    localparam logic signed [22:0] SMIN = 23'(-(1 <<< (DATA_WIDTH - 1)));
    // Row, column and imaginary flag of each R word in packing order
    localparam logic [1:0] ROW [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1,
                                        2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    localparam logic [1:0] COL [16] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                        2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    localparam logic [15:0] IS_IM = 16'b0101_0100_1010_0100;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state_q;
    logic [16*DATA_WIDTH-1:0] r_q;
    logic [7:0]               x_q;
    logic [3:0]               k_q;
    logic signed [22:0]       acc_re_q [4];
    logic signed [22:0]       acc_im_q [4];
    logic signed [22:0]       acc_re_d [4];
    logic signed [22:0]       acc_im_d [4];
    logic signed [PW-1:0]     prod;
    logic signed [22:0]       q, nq, t_re, t_im;
    logic                     a_neg, b_neg;

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [22:0] v);
        return DATA_WIDTH'(v > SMAX ? SMAX : v < SMIN ? SMIN : v);
    endfunction

    always_comb begin
        prod  = PW'($signed(DATA_WIDTH'(r_q >> (DATA_WIDTH * k_q)))) * PW'($signed({1'b0, AMP}));
        q     = 23'((prod + PW'(32768)) >>> 16);
        nq    = -q;
        a_neg = x_q[{COL[k_q], 1'b0}];
        b_neg = x_q[{COL[k_q], 1'b1}];
        t_re  = IS_IM[k_q] ? (b_neg ? q : nq) : (a_neg ? nq : q);
        t_im  = IS_IM[k_q] ? (a_neg ? nq : q) : (b_neg ? nq : q);
        for (int i = 0; i < 4; i++) begin
            acc_re_d[i] = acc_re_q[i] + (ROW[k_q] == 2'(i) ? t_re : 23'sd0);
            acc_im_d[i] = acc_im_q[i] + (ROW[k_q] == 2'(i) ? t_im : 23'sd0);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_y_hat <= '0;
            r_q     <= '0;
            x_q     <= '0;
            k_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                acc_re_q[i] <= '0;
                acc_im_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: if (i_valid) begin
                    r_q     <= i_r;
                    x_q     <= i_x_hardbit;
                    k_q     <= '0;
                    o_ready <= 1'b0;
                    state_q <= MAC;
                    for (int i = 0; i < 4; i++) begin
                        acc_re_q[i] <= '0;
                        acc_im_q[i] <= '0;
                    end
                end
                MAC: begin
                    acc_re_q <= acc_re_d;
                    acc_im_q <= acc_im_d;
                    k_q      <= k_q + 4'd1;
                    if (k_q == 4'd15) begin
                        state_q <= DONE;
                        o_valid <= 1'b1;
                        o_y_hat <= {sat(acc_im_d[3]), sat(acc_re_d[3]), sat(acc_im_d[2]), sat(acc_re_d[2]),
                                    sat(acc_im_d[1]), sat(acc_re_d[1]), sat(acc_im_d[0]), sat(acc_re_d[0])};
                    end
                end
                DONE: if (i_ready) begin
                    state_q <= IDLE;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ml_y_gen.sv
// tb_ml_y_gen: directed table, randomized model comparison, backpressure and reset corners.
module tb_ml_y_gen;
    logic         clk = 1'b0;
    logic         rst, i_valid, i_ready, o_ready, o_valid;
    logic [7:0]   x;
    logic [319:0] r;
    logic [159:0] y;
    int errs = 0, checks = 0;

    ml_y_gen dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_x_hardbit(x), .i_r(r), .o_valid(o_valid), .i_ready(i_ready), .o_y_hat(y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [319:0] r;
        logic [7:0]   x;
        logic [159:0] y;
    } vec_t;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] py(input int v0, v1, v2, v3, v4, v5, v6, v7);
        int v [8];
        logic [159:0] p;
        v = '{v0, v1, v2, v3, v4, v5, v6, v7};
        for (int i = 0; i < 8; i++) p[20*i +: 20] = v[i][19:0];
        return p;
    endfunction

    function automatic longint qof(input logic [319:0] rr, input int n);
        logic signed [19:0] w;
        longint v;
        w = rr[20*n +: 20];
        v = w;
        return (v * 46341 + 32768) >>> 16;
    endfunction

    function automatic logic [19:0] satm(input longint v);
        longint s;
        s = v > 524287 ? 524287 : v < -524288 ? -524288 : v;
        return s[19:0];
    endfunction

    // Column j of R starts at word j*j: {rij.re, rij.im} for i<j, then rjj
    function automatic logic [159:0] model(input logic [319:0] rr, input logic [7:0] xx);
        longint yr [4];
        longint yi [4];
        logic [159:0] p;
        for (int i = 0; i < 4; i++) begin
            yr[i] = 0;
            yi[i] = 0;
        end
        for (int j = 0; j < 4; j++) begin
            longint a, b;
            a = xx[2*j] ? -1 : 1;
            b = xx[2*j+1] ? -1 : 1;
            for (int i = 0; i <= j; i++) begin
                longint qr, qi;
                qr = qof(rr, j*j + 2*i);
                qi = (i == j) ? 0 : qof(rr, j*j + 2*i + 1);
                yr[i] += qr * a - qi * b;
                yi[i] += qr * b + qi * a;
            end
        end
        for (int i = 0; i < 4; i++) begin
            p[40*i +: 20]      = satm(yr[i]);
            p[40*i + 20 +: 20] = satm(yi[i]);
        end
        return p;
    endfunction

    task automatic start(input logic [319:0] rr, input logic [7:0] xx, input string name);
        @(negedge clk);
        chk({name, " ready"}, 160'(o_ready), 160'd1);
        r = rr;
        x = xx;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        r = {10{$urandom()}};
        x = 8'($urandom());
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input logic [319:0] rr, input logic [7:0] xx, input string name,
                       output logic [159:0] yo, output int lat);
        start(rr, xx, name);
        wait_valid(lat);
        yo = y;
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    initial begin
        vec_t tv [6];
        logic [319:0] ident, rr;
        logic [159:0] yo, y0;
        logic [7:0] xx;
        int lat;

        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; r = '0; x = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset o_ready", 160'(o_ready), 160'd1);
        chk("reset o_valid", 160'(o_valid), 160'd0);
        chk("reset y_hat", y, 160'd0);
        @(negedge clk);
        rst = 1'b0;

        ident = '0;
        ident[0 +: 20] = 20'h10000; ident[60 +: 20] = 20'h10000;
        ident[160 +: 20] = 20'h10000; ident[300 +: 20] = 20'h10000;
        tv[0] = '{ident, 8'h00, py(46341, 46341, 46341, 46341, 46341, 46341, 46341, 46341)};
        tv[1] = '{ident, 8'hFF, py(-46341, -46341, -46341, -46341, -46341, -46341, -46341, -46341)};
        tv[2] = '{ident, 8'h01, py(-46341, 46341, 46341, 46341, 46341, 46341, 46341, 46341)};
        rr = '0;
        rr[0 +: 20] = 20'h10000; rr[60 +: 20] = 20'h10000; rr[40 +: 20] = 20'h10000;
        tv[3] = '{rr, 8'h00, py(0, 92682, 46341, 46341, 0, 0, 0, 0)};
        rr = '0;
        foreach (tv[0].y[i]) if (i < 16 && !(i inside {2, 5, 7, 10, 12, 14})) rr[20*i +: 20] = 20'h7FFFF;
        tv[4] = '{rr, 8'h00, py(524287, 524287, 524287, 524287, 524287, 524287, 370727, 370727)};
        rr = '0;
        foreach (tv[0].y[i]) if (i < 16 && !(i inside {2, 5, 7, 10, 12, 14})) rr[20*i +: 20] = 20'h80000;
        tv[5] = '{rr, 8'h00, py(-524288, -524288, -524288, -524288, -524288, -524288, -370728, -370728)};

        for (int i = 0; i < 6; i++) begin
            run(tv[i].r, tv[i].x, $sformatf("vec%0d", i), yo, lat);
            chk($sformatf("vec%0d latency", i), 160'(lat), 160'd16);
            chk($sformatf("vec%0d y_hat", i), yo, tv[i].y);
        end

        for (int i = 0; i < 40; i++) begin
            rr = {10{$urandom()}};
            if (i % 4 == 1) for (int w = 0; w < 16; w++) rr[20*w +: 20] = 20'($urandom_range(0, 131071) - 65536);
            xx = 8'($urandom());
            run(rr, xx, $sformatf("rnd%0d", i), yo, lat);
            chk($sformatf("rnd%0d latency", i), 160'(lat), 160'd16);
            chk($sformatf("rnd%0d y_hat", i), yo, model(rr, xx));
        end

        start(ident, 8'h00, "bp");
        wait_valid(lat);
        chk("bp latency", 160'(lat), 160'd16);
        y0 = y;
        chk("bp y_hat", y0, tv[0].y);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_valid = 1'b1;
            r = {10{$urandom()}};
            x = 8'($urandom());
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d o_valid", c), 160'(o_valid), 160'd1);
            chk($sformatf("bp%0d y_hat", c), y, y0);
            chk($sformatf("bp%0d o_ready", c), 160'(o_ready), 160'd0);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk("bp release o_ready", 160'(o_ready), 160'd1);
        chk("bp release o_valid", 160'(o_valid), 160'd0);

        start(ident, 8'hFF, "rst");
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst o_valid", 160'(o_valid), 160'd0);
        chk("midrst y_hat", y, 160'd0);
        chk("midrst o_ready", 160'(o_ready), 160'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst no emit", 160'(o_valid), 160'd0);
        run(ident, 8'h00, "post", yo, lat);
        chk("post latency", 160'(lat), 160'd16);
        chk("post y_hat", yo, tv[0].y);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
